// File: rtl/vec_pack.sv
// vec_pack: gathers three signed 32-bit scalars from a show-ahead FIFO into a
// 3-component vector and pushes it to a vector FIFO. Scalar k of a triple lands
// in component k. Collection and write phases never overlap, so a vector takes
// at least four cycles.
module vec_pack #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [31:0]   in,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic signed [31:0]   out [2:0],
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [1:0]           idx,
  output logic [CNT_WIDTH-1:0] vec_count
);

  localparam logic S_COLLECT = 1'b0;
  localparam logic S_WRITE   = 1'b1;

  logic                 state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic signed [31:0]   out_q [2:0];

  // Handshake strobes; reset is folded in so neither strobe can fire while
  // reset is held, even though the state register is already in S_COLLECT.
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (!reset) begin
      in_rd_en  = (state_q == S_COLLECT) && !in_empty;
      out_wr_en = (state_q == S_WRITE) && !out_full;
    end
  end

  // Next-state for FSM, component index and vector counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (state_q == S_COLLECT) begin
      if (in_rd_en) begin
        if (idx_q == 2'd2) begin
          idx_d   = 2'd0;
          state_d = S_WRITE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
    end else begin
      if (out_wr_en) begin
        cnt_d   = cnt_q + 1'b1;  // wraps naturally at 2^CNT_WIDTH
        state_d = S_COLLECT;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_COLLECT;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Component capture; only the slot being read changes, others keep their
  // previous-vector contents until overwritten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q[0] <= '0;
      out_q[1] <= '0;
      out_q[2] <= '0;
    end else if (in_rd_en) begin
      out_q[idx_q] <= in;
    end
  end

  // Drive registered values to the ports.
  always_comb begin
    out[0]    = out_q[0];
    out[1]    = out_q[1];
    out[2]    = out_q[2];
    idx       = idx_q;
    vec_count = cnt_q;
  end

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack, run with a 4-bit vector counter so the wrap
// from 15 to 0 is reachable in a short run.
module tb_vec_pack;

  localparam int unsigned CW = 4;

  logic                clock;
  logic                reset;
  logic signed [31:0]  in;
  logic                in_empty;
  logic                in_rd_en;
  logic signed [31:0]  out [2:0];
  logic                out_full;
  logic                out_wr_en;
  logic [1:0]          idx;
  logic [CW-1:0]       vec_count;

  int n_checks;
  int n_errors;

  vec_pack #(.CNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out       (out),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .idx       (idx),
    .vec_count (vec_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, check the strobes, then advance past the edge.
  task automatic step(input logic empty, input logic full, input logic signed [31:0] din,
                      input logic exp_rd, input logic exp_wr, input string tag);
    in_empty = empty;
    out_full = full;
    in       = din;
    #1;
    check({tag, ".rd"}, 64'(in_rd_en), 64'(exp_rd));
    check({tag, ".wr"}, 64'(out_wr_en), 64'(exp_wr));
    @(posedge clock);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic signed [31:0] a,
                           input logic signed [31:0] b, input logic signed [31:0] c);
    check({tag, ".o0"}, 64'(out[0]), 64'(a));
    check({tag, ".o1"}, 64'(out[1]), 64'(b));
    check({tag, ".o2"}, 64'(out[2]), 64'(c));
  endtask

  task automatic run_vector(input logic signed [31:0] a, input logic signed [31:0] b,
                            input logic signed [31:0] c, input string tag);
    step(1'b0, 1'b0, a, 1'b1, 1'b0, tag);
    step(1'b0, 1'b0, b, 1'b1, 1'b0, tag);
    step(1'b0, 1'b0, c, 1'b1, 1'b0, tag);
    check_vec(tag, a, b, c);
    step(1'b0, 1'b0, 32'sd0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    in       = '0;
    in_empty = 1'b0;
    out_full = 1'b0;

    // Reset state: strobes low even with data present and room downstream.
    repeat (2) @(posedge clock);
    #3;
    check("rst.rd", 64'(in_rd_en), 64'd0);
    check("rst.wr", 64'(out_wr_en), 64'd0);
    check("rst.idx", 64'(idx), 64'd0);
    check("rst.cnt", 64'(vec_count), 64'd0);
    check_vec("rst", 32'sd0, 32'sd0, 32'sd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Stream 1..6: writes on cycles 4 and 8 after release.
    step(1'b0, 1'b0, 32'sd1, 1'b1, 1'b0, "s1c1");
    check("s1.idx1", 64'(idx), 64'd1);
    step(1'b0, 1'b0, 32'sd2, 1'b1, 1'b0, "s1c2");
    check("s1.idx2", 64'(idx), 64'd2);
    step(1'b0, 1'b0, 32'sd3, 1'b1, 1'b0, "s1c3");
    check("s1.idx0", 64'(idx), 64'd0);
    check_vec("s1v1", 32'sd1, 32'sd2, 32'sd3);
    step(1'b0, 1'b0, 32'sd99, 1'b0, 1'b1, "s1c4");
    check("s1.cnt1", 64'(vec_count), 64'd1);
    step(1'b0, 1'b0, 32'sd4, 1'b1, 1'b0, "s1c5");
    step(1'b0, 1'b0, 32'sd5, 1'b1, 1'b0, "s1c6");
    step(1'b0, 1'b0, 32'sd6, 1'b1, 1'b0, "s1c7");
    check_vec("s1v2", 32'sd4, 32'sd5, 32'sd6);
    step(1'b0, 1'b0, 32'sd99, 1'b0, 1'b1, "s1c8");
    check("s1.cnt2", 64'(vec_count), 64'd2);

    // Signed values pass bit-exact.
    run_vector(-32'sd1024, 32'sd2048, -32'sd7, "sgn");
    check("sgn.cnt", 64'(vec_count), 64'd3);
    check_vec("sgn.held", -32'sd1024, 32'sd2048, -32'sd7);

    // Empty gap after two scalars; out_full is irrelevant while collecting.
    step(1'b0, 1'b1, 32'sd10, 1'b1, 1'b0, "gap.r1");
    step(1'b0, 1'b1, 32'sd20, 1'b1, 1'b0, "gap.r2");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'sd55, 1'b0, 1'b0, "gap.idle");
      check("gap.idx", 64'(idx), 64'd2);
    end
    step(1'b0, 1'b1, 32'sd30, 1'b1, 1'b0, "gap.r3");
    check_vec("gap", 32'sd10, 32'sd20, 32'sd30);
    step(1'b0, 1'b0, 32'sd0, 1'b0, 1'b1, "gap.w");
    check("gap.cnt", 64'(vec_count), 64'd4);

    // Backpressure: no write and no read while full, one write when it drops.
    step(1'b0, 1'b0, 32'sd40, 1'b1, 1'b0, "bp.r1");
    step(1'b0, 1'b0, 32'sd50, 1'b1, 1'b0, "bp.r2");
    step(1'b0, 1'b0, 32'sd60, 1'b1, 1'b0, "bp.r3");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'sd77, 1'b0, 1'b0, "bp.stall");
    end
    check_vec("bp.held", 32'sd40, 32'sd50, 32'sd60);
    check("bp.cnt0", 64'(vec_count), 64'd4);
    step(1'b0, 1'b0, 32'sd77, 1'b0, 1'b1, "bp.w");
    check("bp.cnt", 64'(vec_count), 64'd5);

    // Reset mid-vector discards the partial vector.
    step(1'b0, 1'b0, 32'sd1, 1'b1, 1'b0, "mr.r1");
    step(1'b0, 1'b0, 32'sd2, 1'b1, 1'b0, "mr.r2");
    check("mr.idx2", 64'(idx), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mr.idx", 64'(idx), 64'd0);
    check("mr.cnt", 64'(vec_count), 64'd0);
    check("mr.rd", 64'(in_rd_en), 64'd0);
    check("mr.wr", 64'(out_wr_en), 64'd0);
    check_vec("mr.clr", 32'sd0, 32'sd0, 32'sd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_vector(32'sd7, 32'sd8, 32'sd9, "mr.v");
    check("mr.cnt1", 64'(vec_count), 64'd1);

    // Counter wrap with a 4-bit counter: 14 more reach 15, one more wraps to 0.
    for (int i = 0; i < 14; i++) begin
      run_vector(32'(i), 32'(i + 100), 32'(-i), "wrap.fill");
    end
    check("wrap.cnt15", 64'(vec_count), 64'd15);
    run_vector(32'sd11, 32'sd12, 32'sd13, "wrap.last");
    check("wrap.cnt0", 64'(vec_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
